// File: rtl/sobel_ctrl_pkg.sv
// sobel_ctrl_pkg: shared FSM encodings and pixel width for the sobel stream controller.
package sobel_ctrl_pkg;
   localparam int PIX_W = 8;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACTIVE = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/sobel_stream_ctrl_kernel.sv
// sobel_stream_ctrl_kernel: combinational 3x3 sobel, |Gx|+|Gy| strictly above threshold.
module sobel_stream_ctrl_kernel
   import sobel_ctrl_pkg::*;
(
   input  logic [PIX_W-1:0] win [9],
   input  logic [PIX_W-1:0] threshold,
   output logic             edge_val
);
   logic [9:0] xp, xn, yp, yn, ax, ay;
   logic [10:0] mag;
   // Positive and negative taps are summed separately so the datapath stays unsigned.
   assign xp = {2'b0, win[2]} + {1'b0, win[5], 1'b0} + {2'b0, win[8]};
   assign xn = {2'b0, win[0]} + {1'b0, win[3], 1'b0} + {2'b0, win[6]};
   assign yp = {2'b0, win[6]} + {1'b0, win[7], 1'b0} + {2'b0, win[8]};
   assign yn = {2'b0, win[0]} + {1'b0, win[1], 1'b0} + {2'b0, win[2]};
   assign ax = xp > xn ? xp - xn : xn - xp;
   assign ay = yp > yn ? yp - yn : yn - yp;
   assign mag = {1'b0, ax} + {1'b0, ay};
   assign edge_val = mag > {3'b0, threshold};
endmodule

// File: rtl/sobel_stream_ctrl.sv
// sobel_stream_ctrl: raster-order pixel stream to edge-bit stream through two line buffers
// and a 3x3 window, one result per accepted pixel with a single output register.
module sobel_stream_ctrl
   import sobel_ctrl_pkg::*;
#(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int COLW   = 10,
   parameter int ROWW   = 9
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [PIX_W-1:0] threshold,
   output logic             busy,
   output logic             frame_done,
   input  logic [PIX_W-1:0] in_pixel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_edge,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last
);
   state_t state;
   logic [COLW-1:0] col;
   logic [ROWW-1:0] row;
   logic [PIX_W-1:0] thr;
   logic fed_all, in_xfer, out_xfer, last_col, last_row, edge_val;
   logic [PIX_W-1:0] lb0 [WIDTH];
   logic [PIX_W-1:0] lb1 [WIDTH];
   logic [PIX_W-1:0] win [9];
   logic [PIX_W-1:0] nwin [9];

   assign in_ready = state == ST_ACTIVE && !fed_all && (!out_valid || out_ready);
   assign in_xfer = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;
   assign last_col = col == COLW'(WIDTH - 1);
   assign last_row = row == ROWW'(HEIGHT - 1);
   // Post-shift window: the incoming column enters on the right.
   assign nwin = '{win[1], win[2], lb1[col], win[4], win[5], lb0[col], win[7], win[8], in_pixel};

   sobel_stream_ctrl_kernel u_kernel (.win(nwin), .threshold(thr), .edge_val(edge_val));

   always_ff @(posedge clock) begin
      if (in_xfer) begin
         lb1[col] <= lb0[col];
         lb0[col] <= in_pixel;
         win <= nwin;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
         col <= '0;
         row <= '0;
         thr <= '0;
         fed_all <= 1'b0;
         busy <= 1'b0;
         frame_done <= 1'b0;
         out_valid <= 1'b0;
         out_edge <= 1'b0;
         out_last <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: if (start) begin
               state <= ST_ACTIVE;
               thr <= threshold;
               col <= '0;
               row <= '0;
               fed_all <= 1'b0;
               busy <= 1'b1;
            end
            ST_ACTIVE: begin
               if (in_xfer) begin
                  col <= last_col ? '0 : col + 1'b1;
                  if (last_col && !last_row) row <= row + 1'b1;
                  if (last_col && last_row) fed_all <= 1'b1;
                  out_valid <= 1'b1;
                  // Borders (and stale columns across the line wrap) are forced to zero.
                  out_edge <= edge_val && row >= ROWW'(2) && col >= COLW'(2);
                  out_last <= last_col && last_row;
               end else if (out_xfer) out_valid <= 1'b0;
               if (out_xfer && out_last) begin
                  state <= ST_DONE;
                  busy <= 1'b0;
                  frame_done <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// tb_sobel_stream_ctrl: scenario tasks against a whole-frame sobel reference model.
module tb_sobel_stream_ctrl;
   localparam int W = 8, H = 4, N = W * H;
   logic clock = 1'b0, reset, start, in_valid, out_ready;
   logic [7:0] threshold, in_pixel;
   logic busy, frame_done, in_ready, out_edge, out_valid, out_last;
   int checks = 0, failures = 0;
   logic [7:0] img [N];
   bit exp_edge [N];
   bit got_edge [64];
   bit got_last [64];
   int n_got, done_cnt, stall_bad, busy_bad, last_cyc, done_cyc, stalls;
   bit timed_out;

   sobel_stream_ctrl #(.WIDTH(W), .HEIGHT(H), .COLW(3), .ROWW(2)) dut (
      .clock(clock), .reset(reset), .start(start), .threshold(threshold), .busy(busy),
      .frame_done(frame_done), .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
      .out_edge(out_edge), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last));

   always #5 clock = ~clock;

   function automatic int px(int r, int c);
      return int'(img[r * W + c]);
   endfunction

   function automatic bit model(int r, int c, int thr);
      int gx, gy;
      if (r < 2 || c < 2) return 1'b0;
      gx = px(r-2, c) + 2 * px(r-1, c) + px(r, c) - px(r-2, c-2) - 2 * px(r-1, c-2) - px(r, c-2);
      gy = px(r, c-2) + 2 * px(r, c-1) + px(r, c) - px(r-2, c-2) - 2 * px(r-2, c-1) - px(r-2, c);
      return ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) > thr;
   endfunction

   // mode 0: uniform a; mode 1: columns 0-3 = a, 4-7 = b; mode 2: random in 0..a
   task automatic fill(input int mode, input int a, input int b);
      for (int i = 0; i < N; i++)
         img[i] = mode == 0 ? 8'(a) : mode == 1 ? 8'((i % W) < 4 ? a : b) : 8'($urandom_range(0, a));
   endtask

   task automatic build_exp(input int thr);
      for (int i = 0; i < N; i++) exp_edge[i] = model(i / W, i % W, thr);
   endtask

   // rmode 0: always ready, 1: 1,0,0,1 pattern, 2: random; vmode 0: always valid, 1: random
   task automatic drive_frame(input logic [7:0] thr, input int rmode, input int vmode,
                              input int abort_at, input int mid_start);
      int pix, post;
      bit seen_done, pv, pe, pl, ms_done;
      n_got = 0; done_cnt = 0; stall_bad = 0; busy_bad = 0; stalls = 0;
      last_cyc = -1; done_cyc = -1; timed_out = 0;
      pix = 0; post = 0; seen_done = 0; pv = 0; pe = 0; pl = 0; ms_done = 0;
      @(negedge clock); start = 1'b1; threshold = thr; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clock); start = 1'b0; threshold = 8'($urandom);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc > 0) @(negedge clock);
         in_valid = pix < N && (vmode == 0 || $urandom_range(0, 2) != 0);
         in_pixel = pix < N ? img[pix] : 8'($urandom);
         out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3)
                                                   : 1'($urandom_range(0, 1));
         start = mid_start >= 0 && pix == mid_start && !ms_done;
         if (start) begin threshold = 8'd255; ms_done = 1; end
         #1;
         if (out_valid && !out_ready) stalls++;
         if (out_valid && !out_ready && in_ready) stall_bad++;
         if (pv && {out_valid, out_edge, out_last} !== {1'b1, pe, pl}) stall_bad++;
         if (in_ready && pix >= N) stall_bad++;
         if (!seen_done && !frame_done && busy !== 1'b1) busy_bad++;
         if (seen_done && !frame_done && (busy !== 1'b0 || out_valid !== 1'b0)) busy_bad++;
         if (frame_done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; seen_done = 1; end
         pv = out_valid && !out_ready; pe = out_edge; pl = out_last;
         if (out_valid && out_ready) begin
            if (n_got < 64) begin got_edge[n_got] = out_edge; got_last[n_got] = out_last; end
            n_got++;
            if (out_last) last_cyc = cyc;
         end
         if (in_valid && in_ready) pix++;
         if (abort_at >= 0 && pix >= abort_at) break;
         if (seen_done) post++;
         if (post > 4) break;
      end
      if (abort_at < 0 && post <= 4) timed_out = 1;
      @(posedge clock); #1;
      in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; threshold = 8'd9; in_pixel = 8'd0;
      @(negedge clock); @(negedge clock); #1;
      checks++;
      if ({busy, frame_done, in_ready, out_valid, out_edge, out_last} !== 6'b0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=000000", {busy, frame_done, in_ready, out_valid, out_edge, out_last});
      end
      reset = 1'b0;
      @(negedge clock); #1;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL idle_in_ready got in_ready=%b busy=%b exp=0 0", in_ready, busy);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_uniform;
      fill(0, 77, 77);
      drive_frame(8'd0, 0, 0, -1, -1);
      checks++;
      if (n_got !== N) begin failures++; $display("FAIL uniform_count got=%0d exp=%0d", n_got, N); end
      for (int i = 0; i < N && i < n_got; i++) begin
         checks++;
         if (got_edge[i] !== 1'b0 || got_last[i] !== (i == N - 1)) begin
            failures++; $display("FAIL uniform_res[%0d] got=%b/%b exp=0/%b", i, got_edge[i], got_last[i], i == N - 1);
         end
      end
      checks++;
      if (done_cnt !== 1 || done_cyc !== last_cyc + 1) begin
         failures++; $display("FAIL uniform_done got cnt=%0d at=%0d exp cnt=1 at=%0d", done_cnt, done_cyc, last_cyc + 1);
      end
      checks++;
      if (timed_out || stall_bad !== 0 || busy_bad !== 0) begin
         failures++; $display("FAIL uniform_protocol got to=%0d stall=%0d busy=%0d exp=0 0 0", timed_out, stall_bad, busy_bad);
      end
   endtask

   task automatic test_step;
      int ones;
      fill(1, 0, 100); build_exp(50);
      drive_frame(8'd50, 0, 0, -1, -1);
      ones = 0;
      checks++;
      if (n_got !== N) begin failures++; $display("FAIL step_count got=%0d exp=%0d", n_got, N); end
      for (int i = 0; i < N && i < n_got; i++) begin
         ones += int'(got_edge[i]);
         checks++;
         if (got_edge[i] !== exp_edge[i] || got_last[i] !== (i == N - 1)) begin
            failures++; $display("FAIL step_res[%0d] got=%b/%b exp=%b/%b", i, got_edge[i], got_last[i], exp_edge[i], i == N - 1);
         end
      end
      checks++;
      if (ones !== 4 || got_edge[2*W+4] !== 1'b1 || got_edge[3*W+5] !== 1'b1) begin
         failures++; $display("FAIL step_positions got ones=%0d exp=4 at r2-3 c4-5", ones);
      end
      checks++;
      if (timed_out || done_cnt !== 1 || stall_bad !== 0 || busy_bad !== 0) begin
         failures++; $display("FAIL step_protocol got to=%0d done=%0d stall=%0d busy=%0d exp=0 1 0 0", timed_out, done_cnt, stall_bad, busy_bad);
      end
   endtask

   task automatic test_threshold;
      int ones;
      fill(1, 0, 10);
      for (int t = 40; t >= 39; t--) begin
         build_exp(t);
         drive_frame(8'(t), 0, 0, -1, -1);
         ones = 0;
         for (int i = 0; i < N && i < n_got; i++) begin
            ones += int'(got_edge[i]);
            checks++;
            if (got_edge[i] !== exp_edge[i]) begin
               failures++; $display("FAIL thr%0d_res[%0d] got=%b exp=%b", t, i, got_edge[i], exp_edge[i]);
            end
         end
         checks++;
         if (n_got !== N || ones !== (t == 40 ? 0 : 4)) begin
            failures++; $display("FAIL thr%0d_ones got n=%0d ones=%0d exp n=%0d ones=%0d", t, n_got, ones, N, t == 40 ? 0 : 4);
         end
      end
   endtask

   task automatic test_backpressure;
      fill(1, 0, 100); build_exp(50);
      drive_frame(8'd50, 1, 0, -1, -1);
      checks++;
      if (n_got !== N) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", n_got, N); end
      for (int i = 0; i < N && i < n_got; i++) begin
         checks++;
         if (got_edge[i] !== exp_edge[i] || got_last[i] !== (i == N - 1)) begin
            failures++; $display("FAIL bp_res[%0d] got=%b/%b exp=%b/%b", i, got_edge[i], got_last[i], exp_edge[i], i == N - 1);
         end
      end
      checks++;
      if (timed_out || stalls == 0 || stall_bad !== 0 || busy_bad !== 0 || done_cnt !== 1) begin
         failures++; $display("FAIL bp_protocol got to=%0d stalls=%0d bad=%0d busy=%0d done=%0d exp 0 >0 0 0 1", timed_out, stalls, stall_bad, busy_bad, done_cnt);
      end
   endtask

   task automatic test_reset_midframe;
      fill(1, 0, 100); build_exp(50);
      drive_frame(8'd50, 2, 1, 13, -1);
      @(negedge clock); reset = 1'b1;
      @(negedge clock); #1;
      checks++;
      if ({busy, frame_done, in_ready, out_valid, out_edge, out_last} !== 6'b0) begin
         failures++;
         $display("FAIL midreset_outputs got=%b exp=000000", {busy, frame_done, in_ready, out_valid, out_edge, out_last});
      end
      reset = 1'b0;
      drive_frame(8'd50, 0, 0, -1, -1);
      checks++;
      if (n_got !== N) begin failures++; $display("FAIL midreset_count got=%0d exp=%0d", n_got, N); end
      for (int i = 0; i < N && i < n_got; i++) begin
         checks++;
         if (got_edge[i] !== exp_edge[i] || got_last[i] !== (i == N - 1)) begin
            failures++; $display("FAIL midreset_res[%0d] got=%b/%b exp=%b/%b", i, got_edge[i], got_last[i], exp_edge[i], i == N - 1);
         end
      end
   endtask

   task automatic test_start_ignored;
      fill(1, 0, 100); build_exp(50);
      drive_frame(8'd50, 0, 0, -1, 10);
      for (int i = 0; i < N && i < n_got; i++) begin
         checks++;
         if (got_edge[i] !== exp_edge[i]) begin
            failures++; $display("FAIL midstart_res[%0d] got=%b exp=%b", i, got_edge[i], exp_edge[i]);
         end
      end
      checks++;
      if (n_got !== N || done_cnt !== 1 || busy_bad !== 0 || timed_out) begin
         failures++; $display("FAIL midstart_protocol got n=%0d done=%0d busy=%0d to=%0d exp %0d 1 0 0", n_got, done_cnt, busy_bad, timed_out, N);
      end
   endtask

   task automatic test_random;
      int thr;
      for (int f = 0; f < 4; f++) begin
         fill(2, 40, 0);
         thr = $urandom_range(0, 150);
         build_exp(thr);
         drive_frame(8'(thr), 2, 1, -1, -1);
         checks++;
         if (n_got !== N || timed_out) begin
            failures++; $display("FAIL rand%0d_count got=%0d to=%0d exp=%0d", f, n_got, timed_out, N);
         end
         for (int i = 0; i < N && i < n_got; i++) begin
            checks++;
            if (got_edge[i] !== exp_edge[i] || got_last[i] !== (i == N - 1)) begin
               failures++; $display("FAIL rand%0d_res[%0d] got=%b/%b exp=%b/%b", f, i, got_edge[i], got_last[i], exp_edge[i], i == N - 1);
            end
         end
         checks++;
         if (stall_bad !== 0 || busy_bad !== 0 || done_cnt !== 1 || done_cyc !== last_cyc + 1) begin
            failures++; $display("FAIL rand%0d_protocol got stall=%0d busy=%0d done=%0d exp 0 0 1", f, stall_bad, busy_bad, done_cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_uniform();
      test_step();
      test_threshold();
      test_backpressure();
      test_reset_midframe();
      test_start_ignored();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sobel_stream_ctrl.md
Name: sobel_stream_ctrl

Overview:
Streaming controller that sequences the combinational 3x3 sobel edge datapath over a raster-order grayscale frame. It accepts one 8-bit pixel per handshake and keeps two line buffers plus a 3x3 window. It feeds the window to one sobel instance and emits one registered edge bit per accepted pixel on an output stream. It sits between the camera/grayscale pixel source and the edge-map writer.

Parameters:
WIDTH, 640, pixels per line (>=3)
HEIGHT, 480, lines per frame (>=3)
COLW, 10, column counter width (>= clog2(WIDTH))
ROWW, 9, row counter width (>= clog2(HEIGHT))

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame, latches threshold
threshold  in  8  edge threshold, sampled only on accepted start
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse after final output handshake
in_pixel  in  8  grayscale pixel, raster order
in_valid  in  1  source has pixel
in_ready  out  1  controller accepts pixel this cycle
out_edge  out  1  edge result
out_valid  out  1  out_edge/out_last valid
out_ready  in  1  sink accepts result
out_last  out  1  marks final result of frame

Behaviour:
- One clock, reset is synchronous and active-high. Reset values: busy=0, frame_done=0, in_ready=0, out_valid=0, out_edge=0, out_last=0; state IDLE, col=row=0, latched threshold=0. Line buffer and window contents are don't-care after reset.
- FSM states:
  - IDLE: in_ready=0. start moves to ACTIVE, latches threshold and clears col/row.
  - ACTIVE: accept pixels. When the output handshake with out_last=1 occurs, move to DONE.
  - DONE: frame_done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored and does not change the latched threshold.
- Handshakes:
  - An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
  - In ACTIVE, in_ready = !out_valid || out_ready. This is a single output register with no bubble under continuous flow.
  - After the last input pixel is accepted, in_ready=0 until IDLE.
  - out_valid stays high and out_edge/out_last stay stable until the output transfer.
- Latency: result appears on out_* the cycle after its input transfer. Throughput is 1 pixel/cycle.
- Window per accepted pixel p at (row r, col c):
  - New column is {lb1[c] (row r-2), lb0[c] (row r-1), p}.
  - Window shifts left and the new column enters on the right.
  - Update lb1[c]<=lb0[c] and lb0[c]<=p.
- Sobel inputs are the post-shift window, row-major: pixel0..2 top row (r-2), pixel3..5 row r-1, pixel6..8 row r, left to right (c-2..c).
- The result for input (r,c) is the edge of center (r-1,c-1). It is forced to 0 when r<2 or c<2. Stale window columns across the line wrap only affect these forced-zero positions.
- Edge rule: |Gx|+|Gy| > threshold, strictly greater.
- Exactly WIDTH*HEIGHT results per frame. out_last=1 only with the result for input (HEIGHT-1, WIDTH-1).
- Counters: col increments per input transfer and wraps WIDTH-1 -> 0 with row+1. No wrap of row beyond HEIGHT-1.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values. The next frame starts cleanly on start, with no leftover out_valid.
- Simultaneous input transfer and output transfer in the same cycle: the register loads the new result, and out_valid stays 1.

Decomposition:
- Shared package/header sobel_ctrl_pkg:
  - FSM state encodings: ST_IDLE, ST_ACTIVE, ST_DONE (2-bit).
  - Localparam PIX_W=8.
- One sub-module instance: the existing sobel combinational kernel (window pixels + latched threshold in, edge_val out).
- Line buffers are inferred register arrays inside sobel_stream_ctrl, with combinational read at index col.

Test Plan:
Bench uses WIDTH=8, HEIGHT=4.
1. Uniform frame (all pixels 77), threshold 0 -> 32 results, all out_edge=0. out_last only on the 32nd. frame_done pulses once, one cycle after it.
2. Vertical step (cols 0-3 =0, cols 4-7 =100), threshold 50 -> out_edge=1 exactly for inputs at r in {2,3}, c in {4,5} (|Gx|=400); all others 0.
3. Threshold boundary, step of 10 (sum 40): threshold 40 -> all 0; repeat with threshold 39 -> the same four positions as scenario 2 give 1.
4. Backpressure: out_ready toggled 1,0,0,1 repeatedly with in_valid constant 1. Check in_ready=0 whenever out_valid && !out_ready, out_* stable while stalled, and the result sequence identical to scenario 2.
5. Reset asserted after 13 input transfers, then start with threshold 50 and the scenario 2 frame -> results identical to scenario 2, with no extra output before the first new result.
6. start pulsed mid-frame with threshold 255 -> ignored: results match threshold 50, busy stays 1, and there is no second frame_done.
